// File: rtl/nfc_verify_pkg.sv
// Shared types and sizing helpers for the NAND copy-path read-back verify engine.
package nfc_verify_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  // Bit width that never collapses to zero for degenerate sizes.
  function automatic int wbits(input int v);
    return (clog2(v) < 1) ? 1 : clog2(v);
  endfunction

  localparam int TOTAL_BEATS = 512 * 512;
  localparam int AW          = clog2(TOTAL_BEATS);

endpackage

// File: rtl/nfc_err_log_fifo.sv
// Show-ahead synchronous FIFO holding mismatch records; push while full is
// accepted only when a pop happens on the same cycle.
module nfc_err_log_fifo
  import nfc_verify_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  localparam int PW   = wbits(DEPTH),
  localparam int CW   = wbits(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         valid,
  output logic [W-1:0] dout,
  output logic         full
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] cnt;
  logic          wr_en, rd_en;

  assign full  = cnt == CW'(DEPTH);
  assign valid = cnt != '0;
  assign dout  = mem[rd_ptr];
  assign rd_en = pop & valid;
  assign wr_en = push & (~full | rd_en);

  always_ff @(posedge clk)
    if (wr_en && !clr) mem[wr_ptr] <= din;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_en) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/nfc_page_verify.sv
// Beat-by-beat compare of expected vs read-back flash streams with page tracking.
// Define NFC_VERIFY_LOG_EN to add the mismatch log FIFO and its ports.
module nfc_page_verify
  import nfc_verify_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int PAGE_BYTES = 512,
  parameter int NUM_PAGES  = 512,
`ifdef NFC_VERIFY_LOG_EN
  parameter int LOG_DEPTH  = 4,
`endif
  localparam int BEATS  = PAGE_BYTES * NUM_PAGES,
  localparam int ADDR_W = wbits(BEATS),
  localparam int PG_W   = wbits(NUM_PAGES),
  localparam int OFF_W  = wbits(PAGE_BYTES)
) (
  input  logic              clk,
  input  logic              rst,
`ifdef NFC_VERIFY_LOG_EN
  input  logic              log_rd,
  output logic              log_valid,
  output logic [ADDR_W-1:0] log_addr,
  output logic [DATA_W-1:0] log_exp,
  output logic [DATA_W-1:0] log_act,
  output logic              log_ovf,
`endif
  input  logic              start,
  input  logic              abort,
  input  logic              a_valid,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W:0]   err_cnt,
  output logic              first_err_valid,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] first_err_exp,
  output logic [DATA_W-1:0] first_err_act,
  output logic              page_done,
  output logic [PG_W-1:0]   page_idx,
  output logic              page_ok
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr;
  logic [OFF_W-1:0]  off;
  logic [PG_W-1:0]   pg;
  logic              page_fail;
  logic              fire, beat, mis, page_end, last_beat, clr;

  // A beat aborted on the same cycle is still consumed, just not counted.
  assign fire      = (state == RUN) & a_valid & b_valid;
  assign beat      = fire & ~abort;
  assign a_ready   = fire;
  assign b_ready   = fire;
  assign mis       = a_data != b_data;
  assign page_end  = off == OFF_W'(PAGE_BYTES - 1);
  assign last_beat = addr == ADDR_W'(BEATS - 1);

  assign busy = state == RUN;
  assign done = state == DONE;
  assign pass = done & (err_cnt == '0);

  always_comb begin
    state_nxt = state;
    clr       = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (abort) state_nxt = IDLE;
        else if (start) begin
          state_nxt = RUN;
          clr       = 1'b1;
        end
      end
      RUN: begin
        if (abort) state_nxt = IDLE;
        else if (beat && last_beat) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      addr            <= '0;
      off             <= '0;
      pg              <= '0;
      page_fail       <= 1'b0;
      err_cnt         <= '0;
      first_err_valid <= 1'b0;
      first_err_addr  <= '0;
      first_err_exp   <= '0;
      first_err_act   <= '0;
      page_done       <= 1'b0;
      page_idx        <= '0;
      page_ok         <= 1'b0;
    end else begin
      state     <= state_nxt;
      page_done <= 1'b0;
      if (clr) begin
        addr            <= '0;
        off             <= '0;
        pg              <= '0;
        page_fail       <= 1'b0;
        err_cnt         <= '0;
        first_err_valid <= 1'b0;
        first_err_addr  <= '0;
        first_err_exp   <= '0;
        first_err_act   <= '0;
      end else if (beat) begin
        addr <= addr + 1'b1;
        if (mis) begin
          if (~&err_cnt) err_cnt <= err_cnt + 1'b1;
          if (!first_err_valid) begin
            first_err_valid <= 1'b1;
            first_err_addr  <= addr;
            first_err_exp   <= a_data;
            first_err_act   <= b_data;
          end
        end
        if (page_end) begin
          off       <= '0;
          pg        <= pg + 1'b1;
          page_done <= 1'b1;
          page_idx  <= pg;
          page_ok   <= ~(page_fail | mis);
          page_fail <= 1'b0;
        end else begin
          off       <= off + 1'b1;
          page_fail <= page_fail | mis;
        end
      end
    end
  end

`ifdef NFC_VERIFY_LOG_EN
  logic log_push, log_pop, log_full;

  assign log_push = beat & mis;
  assign log_pop  = log_rd & log_valid;

  nfc_err_log_fifo #(.W(ADDR_W + 2 * DATA_W), .DEPTH(LOG_DEPTH)) u_log (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .push  (log_push),
    .pop   (log_pop),
    .din   ({addr, a_data, b_data}),
    .valid (log_valid),
    .dout  ({log_addr, log_exp, log_act}),
    .full  (log_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) log_ovf <= 1'b0;
    else if (clr) log_ovf <= 1'b0;
    else if (log_push && log_full && !log_pop) log_ovf <= 1'b1;
  end
`endif

endmodule
